lutram_port_arbiter: RTL and testbench
======================================

LUTRAM_PORT_ARBITER -- requirements
Module: lutram_port_arbiter

Interface
REQ-001 SHALL have parameter CLEAR_VALUE, default 16'h0000: data written to every word during the clear sweep.
REQ-002 SHALL have port clock, input, 1: sole clock; all state updates on posedge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have ports req0_valid/req1_valid, input, 1: requester i presents an access.
REQ-005 SHALL have ports req0_ready/req1_ready, output, 1: access accepted this cycle.
REQ-006 SHALL have ports req0_we/req1_we, input, 1: 1 = write, 0 = read.
REQ-007 SHALL have ports req0_addr/req1_addr, input, 5: word address 0..31.
REQ-008 SHALL have ports req0_wdata/req1_wdata, input, 16: write data.
REQ-009 SHALL have ports rsp0_valid/rsp1_valid, output, 1: read data valid, one-cycle pulse.
REQ-010 SHALL have ports rsp0_rdata/rsp1_rdata, output, 16: registered read data.
REQ-011 SHALL have port ram_we, output, 1: write enable to the 32x16 LUT RAM.
REQ-012 SHALL have port ram_addr, output, 5: RAM address (shared read/write).
REQ-013 SHALL have port ram_din, output, 16: RAM write data.
REQ-014 SHALL have port ram_dout, input, 16: RAM asynchronous read data.
REQ-015 SHALL have port busy, output, 1: high while the clear sweep runs.

Function
REQ-016 SHALL implement states CLEAR and ACTIVE; CLEAR exits to ACTIVE after address 31 is written.
REQ-017 In CLEAR, SHALL drive ram_we=1, ram_din=CLEAR_VALUE, ram_addr=sweep counter (0..31, +1 per cycle), busy=1, both ready=0.
REQ-018 In ACTIVE, SHALL grant at most one requester per cycle; readyi=1 only for the winner, combinationally from the valids.
REQ-019 Single valid SHALL always win; both valid SHALL grant the requester not granted most recently (round-robin).
REQ-020 Last-grant pointer SHALL update only on a completed transfer (valid & ready).
REQ-021 On grant, ram_addr/ram_din SHALL be the winner's addr/wdata; ram_we = winner's we; with no grant ram_we=0, ram_addr=0, ram_din=0.
REQ-022 Granted read SHALL assert rspi_valid exactly one cycle later for one cycle, rspi_rdata = ram_dout sampled at the grant edge.
REQ-023 Writes SHALL produce no response; rspi_rdata SHALL hold its last value while rspi_valid=0.
REQ-024 Write at cycle N then read of same address at N+1 SHALL return the new data.
REQ-025 Back-to-back reads by one requester SHALL sustain one access per cycle while the other is idle.

Reset
REQ-026 reset_n low SHALL immediately force: rsp*_valid=0, rsp*_rdata=0, sweep counter=0, last-grant pointer=requester 1 (requester 0 wins the first tie).
REQ-027 State after reset SHALL be CLEAR if LUTRAM_ARB_CLEAR_EN is defined, else ACTIVE; reset mid-sweep SHALL restart the sweep at address 0.
REQ-028 A read granted in the cycle reset asserts SHALL produce no response.

Configuration
REQ-029 Macro LUTRAM_ARB_CLEAR_EN defined: CLEAR state and sweep counter SHALL exist; busy follows REQ-017.
REQ-030 Macro undefined: CLEAR logic SHALL be absent, busy tied 0, arbitration available from the first cycle after reset release.

Structure
REQ-031 Package lutram_arb_pkg SHALL hold ADDR_W=5, DATA_W=16, DEPTH=32 and the state enum.
REQ-032 Two-way round-robin grant logic SHALL be a sub-module rr_arbiter2 (inputs req[1:0], last; output gnt[1:0]).

Verification
REQ-033 CLEAR_EN, release reset: busy=1 for 32 cycles, ram_we=1 addr 0..31 din 0, then busy=0; read addr 7 -> rsp rdata 0x0000.
REQ-034 r0 writes 0xBEEF@5 at N, r1 reads 5 at N+1 -> rsp1_valid at N+2, rdata 0xBEEF.
REQ-035 Both valid continuously, reads to 1 and 2 -> grants alternate r0,r1,r0,... starting r0; each rsp one cycle after grant.
REQ-036 Only r1 valid for 4 cycles -> r1 granted every cycle, 4 responses, r0 ready stays 0.
REQ-037 reset_n pulsed low during sweep at address 12 -> outputs cleared at once; sweep restarts at 0 after release.
REQ-038 Without CLEAR_EN: busy=0 and r0 write accepted first cycle after reset release.

Source files
------------

// File: rtl/lutram_arb_pkg.sv
// Shared widths and controller state for the two-port LUT RAM arbiter.
// Optional power-up clear sweep is enabled with LUTRAM_ARB_CLEAR_EN.
package lutram_arb_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 32;

    typedef enum logic {
        CLEAR,
        ACTIVE
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone request always wins, a tie goes
// to the requester that was not granted most recently.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/lutram_port_arbiter.sv
// Two requesters sharing one 32x16 LUT RAM port with registered read data.
// LUTRAM_ARB_CLEAR_EN adds a post-reset sweep writing CLEAR_VALUE everywhere.
module lutram_port_arbiter
    import lutram_arb_pkg::*;
#(
    parameter logic [DATA_W-1:0] CLEAR_VALUE = 16'h0000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy
);

    logic              sweep;
    logic [ADDR_W-1:0] sweep_addr;
    logic [1:0]        arb_gnt;
    logic [1:0]        gnt;
    logic              rd0;
    logic              rd1;
    logic              last_q;
    logic              last_d;
    logic              rsp0_valid_q;
    logic              rsp1_valid_q;
    logic [DATA_W-1:0] rsp0_rdata_q;
    logic [DATA_W-1:0] rsp1_rdata_q;

`ifdef LUTRAM_ARB_CLEAR_EN
    state_e            state_q;
    logic [ADDR_W-1:0] cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else if (state_q == CLEAR) begin
            cnt_q <= cnt_q + ADDR_W'(1);
            if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                state_q <= ACTIVE;
            end
        end
    end

    assign sweep      = (state_q == CLEAR);
    assign sweep_addr = cnt_q;
`else
    assign sweep      = 1'b0;
    assign sweep_addr = '0;
`endif

    rr_arbiter2 u_arb (
        .req  ({req1_valid, req0_valid}),
        .last (last_q),
        .gnt  (arb_gnt)
    );

    // The sweep owns the RAM port outright; nobody is granted meanwhile.
    assign gnt        = sweep ? 2'b00 : arb_gnt;
    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign busy       = sweep;

    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        unique case (1'b1)
            sweep: begin
                ram_we   = 1'b1;
                ram_addr = sweep_addr;
                ram_din  = CLEAR_VALUE;
            end
            gnt[0]: begin
                ram_we   = req0_we;
                ram_addr = req0_addr;
                ram_din  = req0_wdata;
            end
            gnt[1]: begin
                ram_we   = req1_we;
                ram_addr = req1_addr;
                ram_din  = req1_wdata;
            end
            default: begin
                ram_we   = 1'b0;
                ram_addr = '0;
                ram_din  = '0;
            end
        endcase
    end

    assign rd0 = gnt[0] & ~req0_we;
    assign rd1 = gnt[1] & ~req1_we;

    always_comb begin
        last_d = last_q;
        if (gnt[0]) begin
            last_d = 1'b0;
        end else if (gnt[1]) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_q       <= 1'b1;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            last_q       <= last_d;
            rsp0_valid_q <= rd0;
            rsp1_valid_q <= rd1;
            if (rd0) begin
                rsp0_rdata_q <= ram_dout;
            end
            if (rd1) begin
                rsp1_rdata_q <= ram_dout;
            end
        end
    end

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp1_rdata = rsp1_rdata_q;

endmodule

// File: tb/tb_lutram_port_arbiter.sv
// Self-checking bench for lutram_port_arbiter: directed table, reset
// corner cases and randomized traffic against a behavioural model.
module tb_lutram_port_arbiter;

    logic        clock;
    logic        reset_n;
    logic        req0_valid, req0_ready, req0_we;
    logic [4:0]  req0_addr;
    logic [15:0] req0_wdata;
    logic        req1_valid, req1_ready, req1_we;
    logic [4:0]  req1_addr;
    logic [15:0] req1_wdata;
    logic        rsp0_valid, rsp1_valid;
    logic [15:0] rsp0_rdata, rsp1_rdata;
    logic        ram_we;
    logic [4:0]  ram_addr;
    logic [15:0] ram_din, ram_dout;
    logic        busy;

    logic [15:0] mem [32];

    int checks = 0;
    int errors = 0;

    // behavioural model state
    logic [15:0] shadow [32];
    int          last_m;
    logic [1:0]  pv;
    logic [15:0] rd_m [2];

    lutram_port_arbiter #(.CLEAR_VALUE(16'h0000)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout),
        .busy       (busy)
    );

    assign ram_dout = mem[ram_addr];

    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_din;
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic        v0, we0;
        logic [4:0]  a0;
        logic [15:0] d0;
        logic        v1, we1;
        logic [4:0]  a1;
        logic [15:0] d1;
        logic        e_rdy0, e_rdy1, e_we;
        logic [4:0]  e_addr;
        logic [15:0] e_din;
        logic        e_v0;
        logic [15:0] e_rd0;
        logic        e_v1;
        logic [15:0] e_rd1;
    } vec_t;

    localparam logic T = 1'b1;
    localparam logic F = 1'b0;
    localparam int NV = 14;
    vec_t tbl [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    endtask

    task automatic run_sweep(input int abort_at);
        for (int i = 0; i < 32; i++) begin
            req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 5'd7;
            req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 5'd3;
            req1_wdata = 16'hFFFF;
            #1;
            chk($sformatf("sweep%0d_busy", i), 32'(busy), 32'd1);
            chk($sformatf("sweep%0d_we", i), 32'(ram_we), 32'd1);
            chk($sformatf("sweep%0d_addr", i), 32'(ram_addr), 32'(i));
            chk($sformatf("sweep%0d_din", i), 32'(ram_din), 32'h0);
            chk($sformatf("sweep%0d_rdy", i),
                32'({req1_ready, req0_ready}), 32'd0);
            if (i == abort_at) begin
                reset_n = 1'b0;
                #1;
                chk("abort_addr", 32'(ram_addr), 32'd0);
                chk("abort_rsp", 32'({rsp1_valid, rsp0_valid}), 32'd0);
                idle();
                return;
            end
            @(negedge clock);
        end
        idle();
        #1;
        chk("sweep_done_busy", 32'(busy), 32'd0);
    endtask

    // One cycle against the model: check responses, drive, check grant.
    task automatic step(input logic v0, input logic we0, input logic [4:0] a0,
                        input logic [15:0] d0, input logic v1, input logic we1,
                        input logic [4:0] a1, input logic [15:0] d1);
        int w;
        logic        e_we;
        logic [4:0]  e_a;
        logic [15:0] e_d;
        chk("m_rsp0_valid", 32'(rsp0_valid), 32'(pv[0]));
        chk("m_rsp1_valid", 32'(rsp1_valid), 32'(pv[1]));
        chk("m_rsp0_rdata", 32'(rsp0_rdata), 32'(rd_m[0]));
        chk("m_rsp1_rdata", 32'(rsp1_rdata), 32'(rd_m[1]));
        req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
        #1;
        if (v0 && v1) w = (last_m == 0) ? 1 : 0;
        else if (v0) w = 0;
        else if (v1) w = 1;
        else w = -1;
        e_we = 1'b0; e_a = '0; e_d = '0;
        if (w == 0) begin e_we = we0; e_a = a0; e_d = d0; end
        if (w == 1) begin e_we = we1; e_a = a1; e_d = d1; end
        chk("m_ready0", 32'(req0_ready), 32'(w == 0));
        chk("m_ready1", 32'(req1_ready), 32'(w == 1));
        chk("m_ram_we", 32'(ram_we), 32'(e_we));
        chk("m_ram_addr", 32'(ram_addr), 32'(e_a));
        chk("m_ram_din", 32'(ram_din), 32'(e_d));
        pv = 2'b00;
        if (w >= 0) begin
            if (e_we) shadow[e_a] = e_d;
            else begin
                pv[w] = 1'b1;
                rd_m[w] = shadow[e_a];
            end
            last_m = w;
        end
        @(negedge clock);
    endtask

    initial begin
        tbl[0]  = '{T,T,5'd1,16'h1111, F,F,5'd0,16'h0,    T,F,T,5'd1,16'h1111, F,16'h0,    F,16'h0};
        tbl[1]  = '{F,F,5'd0,16'h0,    T,T,5'd2,16'h2222, F,T,T,5'd2,16'h2222, F,16'h0,    F,16'h0};
        tbl[2]  = '{T,T,5'd5,16'hBEEF, F,F,5'd0,16'h0,    T,F,T,5'd5,16'hBEEF, F,16'h0,    F,16'h0};
        tbl[3]  = '{F,F,5'd0,16'h0,    T,F,5'd5,16'h0,    F,T,F,5'd5,16'h0,    F,16'h0,    F,16'h0};
        tbl[4]  = '{T,F,5'd1,16'h0,    T,F,5'd2,16'h0,    T,F,F,5'd1,16'h0,    F,16'h0,    T,16'hBEEF};
        tbl[5]  = '{T,F,5'd1,16'h0,    T,F,5'd2,16'h0,    F,T,F,5'd2,16'h0,    T,16'h1111, F,16'hBEEF};
        tbl[6]  = '{T,F,5'd1,16'h0,    T,F,5'd2,16'h0,    T,F,F,5'd1,16'h0,    F,16'h1111, T,16'h2222};
        tbl[7]  = '{T,F,5'd1,16'h0,    T,F,5'd2,16'h0,    F,T,F,5'd2,16'h0,    T,16'h1111, F,16'h2222};
        tbl[8]  = '{F,F,5'd0,16'h0,    T,F,5'd5,16'h0,    F,T,F,5'd5,16'h0,    F,16'h1111, T,16'h2222};
        tbl[9]  = '{F,F,5'd0,16'h0,    T,F,5'd1,16'h0,    F,T,F,5'd1,16'h0,    F,16'h1111, T,16'hBEEF};
        tbl[10] = '{F,F,5'd0,16'h0,    T,F,5'd2,16'h0,    F,T,F,5'd2,16'h0,    F,16'h1111, T,16'h1111};
        tbl[11] = '{F,F,5'd0,16'h0,    T,F,5'd5,16'h0,    F,T,F,5'd5,16'h0,    F,16'h1111, T,16'h2222};
        tbl[12] = '{F,F,5'd0,16'h0,    F,F,5'd0,16'h0,    F,F,F,5'd0,16'h0,    F,16'h1111, T,16'hBEEF};
        tbl[13] = '{F,F,5'd0,16'h0,    F,F,5'd0,16'h0,    F,F,F,5'd0,16'h0,    F,16'h1111, F,16'hBEEF};

        reset_n = 1'b0;
        idle();
        repeat (3) @(negedge clock);
        chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        chk("rst_rsp0_rdata", 32'(rsp0_rdata), 32'd0);
        chk("rst_rsp1_rdata", 32'(rsp1_rdata), 32'd0);
`ifdef LUTRAM_ARB_CLEAR_EN
        chk("rst_busy", 32'(busy), 32'd1);
        reset_n = 1'b1;
        run_sweep(-1);
`else
        reset_n = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
`endif

        for (int i = 0; i < NV; i++) begin
            req0_valid = tbl[i].v0; req0_we = tbl[i].we0;
            req0_addr = tbl[i].a0; req0_wdata = tbl[i].d0;
            req1_valid = tbl[i].v1; req1_we = tbl[i].we1;
            req1_addr = tbl[i].a1; req1_wdata = tbl[i].d1;
            #1;
            chk($sformatf("tbl%0d_rdy0", i), 32'(req0_ready), 32'(tbl[i].e_rdy0));
            chk($sformatf("tbl%0d_rdy1", i), 32'(req1_ready), 32'(tbl[i].e_rdy1));
            chk($sformatf("tbl%0d_we", i), 32'(ram_we), 32'(tbl[i].e_we));
            chk($sformatf("tbl%0d_addr", i), 32'(ram_addr), 32'(tbl[i].e_addr));
            chk($sformatf("tbl%0d_din", i), 32'(ram_din), 32'(tbl[i].e_din));
            chk($sformatf("tbl%0d_v0", i), 32'(rsp0_valid), 32'(tbl[i].e_v0));
            chk($sformatf("tbl%0d_rd0", i), 32'(rsp0_rdata), 32'(tbl[i].e_rd0));
            chk($sformatf("tbl%0d_v1", i), 32'(rsp1_valid), 32'(tbl[i].e_v1));
            chk($sformatf("tbl%0d_rd1", i), 32'(rsp1_rdata), 32'(tbl[i].e_rd1));
            @(negedge clock);
        end

        // read granted in the cycle reset asserts must not answer
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 5'd5;
        #1;
        chk("rstrd_ready0", 32'(req0_ready), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rstrd_rsp0_async", 32'(rsp0_valid), 32'd0);
        chk("rstrd_rdata0_async", 32'(rsp0_rdata), 32'd0);
        chk("rstrd_rdata1_async", 32'(rsp1_rdata), 32'd0);
        @(posedge clock);
        #1;
        chk("rstrd_rsp0_dropped", 32'(rsp0_valid), 32'd0);
        @(negedge clock);
        idle();

        for (int a = 0; a < 32; a++) shadow[a] = 16'h0000;
        last_m = 1;
        pv = 2'b00;
        rd_m[0] = 16'h0;
        rd_m[1] = 16'h0;

`ifdef LUTRAM_ARB_CLEAR_EN
        reset_n = 1'b1;
        run_sweep(12);
        @(negedge clock);
        reset_n = 1'b1;
        run_sweep(-1);
        step(T, F, 5'd7, 16'h0, F, F, 5'd0, 16'h0);
        step(T, T, 5'd9, 16'hA5A5, F, F, 5'd0, 16'h0);
        step(F, F, 5'd0, 16'h0, T, F, 5'd9, 16'h0);
        step(T, F, 5'd5, 16'h0, F, F, 5'd0, 16'h0);
        step(F, F, 5'd0, 16'h0, F, F, 5'd0, 16'h0);
`else
        reset_n = 1'b1;
        #1;
        chk("norst_busy", 32'(busy), 32'd0);
        step(T, T, 5'd9, 16'hA5A5, F, F, 5'd0, 16'h0);
        step(F, F, 5'd0, 16'h0, T, F, 5'd9, 16'h0);
        step(F, F, 5'd0, 16'h0, F, F, 5'd0, 16'h0);
`endif

        for (int a = 0; a < 32; a++) begin
            step(T, T, 5'(a), 16'($urandom), F, F, 5'd0, 16'h0);
        end

        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5'($urandom), 16'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5'($urandom), 16'($urandom));
        end
        step(F, F, 5'd0, 16'h0, F, F, 5'd0, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
